// File: rtl/rr_mux_arb_if.sv
// ---------------------------------------------------------------------------
// rr_mux_arb_if
//   Stream bundle for the arbitrated multiplexer rr_mux_arb.
//   The N producer streams and the single merged consumer stream share one
//   interface so that a parameterised instance carries consistent widths.
//
//   Parameters
//     N      number of producer channels (N >= 2)
//     WIDTH  data width per channel (WIDTH >= 1)
//     SELW   derived index width, $clog2(N)
//
//   Signals
//     in_valid  [N]        producer i offers a word
//     in_data   [N*WIDTH]  producer i word at [i*WIDTH +: WIDTH]
//     in_ready  [N]        producer i word taken this cycle (one-hot or zero)
//     out_valid            merged output register holds a word
//     out_data  [WIDTH]    merged output word
//     out_sel   [SELW]     channel that supplied out_data
//     out_ready            consumer takes out_data this cycle
//
//   Modports
//     slave   the arbiter side (consumes producers, drives the merged stream)
//     master  the environment side (producers plus consumer)
// ---------------------------------------------------------------------------
interface rr_mux_arb_if #(
    parameter int N     = 4,
    parameter int WIDTH = 8
);
    localparam int SELW = $clog2(N);

    logic [N-1:0]       in_valid;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_sel;
    logic               out_ready;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_sel
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_sel
    );
endinterface

// File: rtl/rr_mux_arb.sv
// ---------------------------------------------------------------------------
// rr_mux_arb
//   N-channel registered multiplexer with internal arbitration. Each cycle in
//   which the output register can load, one valid producer is granted; its
//   word is registered onto the merged output together with its channel
//   index. Round-robin (MODE=0) or fixed priority, channel 0 first (MODE=1).
//
//   Parameters
//     N      number of input channels, N >= 2
//     WIDTH  data width per channel, WIDTH >= 1
//     MODE   0 = round-robin, 1 = fixed priority
//
//   Ports
//     clk    system clock, all state updates on the rising edge
//     rst    synchronous active-high reset; clears the output register and
//            the round-robin pointer, and blocks every in_ready while high
//     bus    rr_mux_arb_if.slave: producer valid/data/ready and the merged
//            valid/data/sel/ready stream
//
//   Timing
//     in_ready is combinational from in_valid, out_ready and internal state
//     (never from in_data). A word accepted at an edge is visible on the
//     output in the following cycle. With out_ready held high the block moves
//     one word per cycle: an output word draining at an edge is replaced by a
//     new word at the same edge.
// ---------------------------------------------------------------------------
module rr_mux_arb #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int MODE  = 0
) (
    input  logic        clk,
    input  logic        rst,
    rr_mux_arb_if.slave bus
);
    localparam int SELW = $clog2(N);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic             out_valid_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic [SELW-1:0]  out_sel_reg;
    // Channel searched first on the next round-robin decision. Always < N.
    logic [SELW-1:0]  rr_ptr_reg;

    // -----------------------------------------------------------------------
    // Arbitration signals
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] data_arr [N];
    logic [N-1:0]     hi_mask;    // channels at or above rr_ptr
    logic [N-1:0]     req_hi;     // requests at or above rr_ptr
    logic [N-1:0]     req_sel;    // request set the lowest-index search runs on
    logic [N-1:0]     gnt_oh;     // one-hot grant, zero when nobody requests
    logic [N-1:0]     bit_terms [SELW];
    logic [SELW-1:0]  grant;
    logic [SELW-1:0]  ptr_next;
    logic             any_valid;
    logic             load;

    // The output register can take a word when it is empty or draining now.
    assign load      = ~out_valid_reg | bus.out_ready;
    assign any_valid = |bus.in_valid;

    // Round-robin as a two-pass priority search: first look for the lowest
    // requester at or above rr_ptr; if there is none the search wraps, which
    // is the same as taking the lowest requester overall. Fixed priority is
    // the degenerate case where every channel counts as "above".
    assign req_hi  = bus.in_valid & hi_mask;
    assign req_sel = (|req_hi) ? req_hi : bus.in_valid;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_chan
            // Mask of all channels strictly below gi.
            localparam logic [N-1:0] LOW_MASK = (N'(1) << gi) - N'(1);

            assign data_arr[gi] = bus.in_data[gi*WIDTH +: WIDTH];

            if (MODE == 0) begin : g_rr
                assign hi_mask[gi] = (rr_ptr_reg <= SELW'(gi));
            end else begin : g_fixed
                assign hi_mask[gi] = 1'b1;
            end

            // Lowest set bit of req_sel wins.
            assign gnt_oh[gi] = req_sel[gi] & ~(|(req_sel & LOW_MASK));

            // Nothing is accepted while reset is asserted: that word would be
            // thrown away by the reset at the same edge.
            assign bus.in_ready[gi] = ~rst & load & gnt_oh[gi];
        end
    endgenerate

    // One-hot to binary: bit gb of the index is the OR of the grant bits of
    // every channel whose index has bit gb set.
    genvar gb;
    generate
        for (gb = 0; gb < SELW; gb++) begin : g_enc_bit
            for (gi = 0; gi < N; gi++) begin : g_enc_chan
                if (((gi >> gb) % 2) == 1) begin : g_set
                    assign bit_terms[gb][gi] = gnt_oh[gi];
                end else begin : g_clr
                    assign bit_terms[gb][gi] = 1'b0;
                end
            end
            assign grant[gb] = |bit_terms[gb];
        end
    endgenerate

    // Pointer moves to the channel after the one just granted, wrapping
    // explicitly so a non-power-of-two N never yields an index >= N.
    assign ptr_next = (grant == SELW'(N - 1)) ? '0 : grant + SELW'(1);

    // -----------------------------------------------------------------------
    // Output register and pointer
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_sel_reg   <= '0;
            rr_ptr_reg    <= '0;
        end else if (load) begin
            if (any_valid) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= data_arr[grant];
                out_sel_reg   <= grant;
                if (MODE == 0) begin
                    rr_ptr_reg <= ptr_next;
                end
            end else begin
                // Empty or drained with no new word: data/sel keep the last
                // value, only the valid flag drops.
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.out_sel   = out_sel_reg;

endmodule

// File: tb/tb_rr_mux_arb.sv
// ---------------------------------------------------------------------------
// tb_rr_mux_arb
//   Directed bench for rr_mux_arb with three instances:
//     u0  N=4 WIDTH=8  round-robin     (reset, rotation, backpressure, wrap)
//     u1  N=4 WIDTH=8  fixed priority  (starvation and hand-over)
//     u2  N=3 WIDTH=16 round-robin     (reset mid-transfer, odd-N wrap)
//   Each table row gives the inputs for one cycle and the outputs expected in
//   that same cycle (before the next rising edge).
// ---------------------------------------------------------------------------
module tb_rr_mux_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0 = 1'b1;
    logic rst1 = 1'b1;
    logic rst2 = 1'b1;

    rr_mux_arb_if #(.N(4), .WIDTH(8))  b0 ();
    rr_mux_arb_if #(.N(4), .WIDTH(8))  b1 ();
    rr_mux_arb_if #(.N(3), .WIDTH(16)) b2 ();

    rr_mux_arb #(.N(4), .WIDTH(8),  .MODE(0)) u0 (.clk(clk), .rst(rst0), .bus(b0));
    rr_mux_arb #(.N(4), .WIDTH(8),  .MODE(1)) u1 (.clk(clk), .rst(rst1), .bus(b1));
    rr_mux_arb #(.N(3), .WIDTH(16), .MODE(0)) u2 (.clk(clk), .rst(rst2), .bus(b2));

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] iv;
        logic       ordy;
        logic [3:0] e_ir;
        logic       e_ov;
        logic [1:0] e_sel;
        logic [7:0] e_data;
    } vec_t;

    vec_t tv0 [24];
    vec_t tv1 [9];

    function automatic vec_t mk(input logic [3:0] iv, input logic ordy,
                                input logic [3:0] ir, input logic ov,
                                input logic [1:0] sel, input logic [7:0] d);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.e_ir = ir; v.e_ov = ov; v.e_sel = sel; v.e_data = d;
        return v;
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %0h want %0h", nm, k, act, exp);
        end
    endtask

    // Apply one row to u0 (dut=0) or u1 (dut=1). Called at posedge+1,
    // checks at posedge+2, returns at the following posedge+1.
    task automatic apply_vec(input int dut, input int k, input vec_t v);
        logic [3:0] a_ir;
        logic       a_ov;
        logic [1:0] a_sel;
        logic [7:0] a_data;
        if (dut == 0) begin
            b0.in_valid = v.iv; b0.out_ready = v.ordy;
        end else begin
            b1.in_valid = v.iv; b1.out_ready = v.ordy;
        end
        #1;
        if (dut == 0) begin
            a_ir = b0.in_ready; a_ov = b0.out_valid; a_sel = b0.out_sel; a_data = b0.out_data;
        end else begin
            a_ir = b1.in_ready; a_ov = b1.out_valid; a_sel = b1.out_sel; a_data = b1.out_data;
        end
        $display("u%0d row %0d: iv=%b ordy=%b -> ir=%b ov=%b sel=%0d data=%h",
                 dut, k, v.iv, v.ordy, a_ir, a_ov, a_sel, a_data);
        chk($sformatf("u%0d.in_ready", dut),  k, 32'(a_ir),   32'(v.e_ir));
        chk($sformatf("u%0d.out_valid", dut), k, 32'(a_ov),   32'(v.e_ov));
        chk($sformatf("u%0d.out_sel", dut),   k, 32'(a_sel),  32'(v.e_sel));
        chk($sformatf("u%0d.out_data", dut),  k, 32'(a_data), 32'(v.e_data));
        @(posedge clk);
        #1;
    endtask

    // One cycle on the N=3 / WIDTH=16 instance.
    task automatic step2(input int k, input logic r, input logic [2:0] iv, input logic ordy,
                         input logic [2:0] e_ir, input logic e_ov, input logic [1:0] e_sel,
                         input logic [15:0] e_data);
        rst2 = r;
        b2.in_valid  = iv;
        b2.out_ready = ordy;
        #1;
        $display("u2 step %0d: rst=%b iv=%b ordy=%b -> ir=%b ov=%b sel=%0d data=%h",
                 k, r, iv, ordy, b2.in_ready, b2.out_valid, b2.out_sel, b2.out_data);
        chk("u2.in_ready",  k, 32'(b2.in_ready),  32'(e_ir));
        chk("u2.out_valid", k, 32'(b2.out_valid), 32'(e_ov));
        chk("u2.out_sel",   k, 32'(b2.out_sel),   32'(e_sel));
        chk("u2.out_data",  k, 32'(b2.out_data),  32'(e_data));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        b0.in_valid = '0; b0.out_ready = 1'b0; b0.in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        b1.in_valid = '0; b1.out_ready = 1'b0; b1.in_data = {8'h53, 8'h52, 8'h51, 8'h50};
        b2.in_valid = '0; b2.out_ready = 1'b0; b2.in_data = {16'hC002, 16'hC001, 16'hC000};

        // ---- u0: round-robin, N=4 ----
        // rows 0-1: reset held with every channel valid
        tv0[0]  = mk(4'hF, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00);
        tv0[1]  = mk(4'hF, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00);
        // rows 2-6: rotation 0,1,2,3,0 with no bubbles
        tv0[2]  = mk(4'hF, 1'b1, 4'b0001, 1'b0, 2'd0, 8'h00);
        tv0[3]  = mk(4'hF, 1'b1, 4'b0010, 1'b1, 2'd0, 8'hA0);
        tv0[4]  = mk(4'hF, 1'b1, 4'b0100, 1'b1, 2'd1, 8'hA1);
        tv0[5]  = mk(4'hF, 1'b1, 4'b1000, 1'b1, 2'd2, 8'hA2);
        tv0[6]  = mk(4'hF, 1'b1, 4'b0001, 1'b1, 2'd3, 8'hA3);
        // rows 7-11: backpressure, word A0 held, nothing accepted
        tv0[7]  = mk(4'hF, 1'b0, 4'b0000, 1'b1, 2'd0, 8'hA0);
        tv0[8]  = mk(4'hF, 1'b0, 4'b0000, 1'b1, 2'd0, 8'hA0);
        tv0[9]  = mk(4'hF, 1'b0, 4'b0000, 1'b1, 2'd0, 8'hA0);
        tv0[10] = mk(4'hF, 1'b0, 4'b0000, 1'b1, 2'd0, 8'hA0);
        tv0[11] = mk(4'hF, 1'b0, 4'b0000, 1'b1, 2'd0, 8'hA0);
        // rows 12-13: release, rotation resumes at ch1 then ch2
        tv0[12] = mk(4'hF, 1'b1, 4'b0010, 1'b1, 2'd0, 8'hA0);
        tv0[13] = mk(4'hF, 1'b1, 4'b0100, 1'b1, 2'd1, 8'hA1);
        // rows 14-18: rr_ptr=3, only ch0/ch1 valid -> 0,1,0; then idle drains
        tv0[14] = mk(4'b0011, 1'b1, 4'b0001, 1'b1, 2'd2, 8'hA2);
        tv0[15] = mk(4'b0011, 1'b1, 4'b0010, 1'b1, 2'd0, 8'hA0);
        tv0[16] = mk(4'b0011, 1'b1, 4'b0001, 1'b1, 2'd1, 8'hA1);
        tv0[17] = mk(4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 8'hA0);
        tv0[18] = mk(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 8'hA0);
        // rows 19-23: empty register loads even with out_ready low
        tv0[19] = mk(4'b0100, 1'b0, 4'b0100, 1'b0, 2'd0, 8'hA0);
        tv0[20] = mk(4'b0100, 1'b0, 4'b0000, 1'b1, 2'd2, 8'hA2);
        tv0[21] = mk(4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2);
        tv0[22] = mk(4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2, 8'hA2);
        tv0[23] = mk(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 8'hA2);

        // ---- u1: fixed priority ----
        tv1[0] = mk(4'b1010, 1'b1, 4'b0010, 1'b0, 2'd0, 8'h00);
        tv1[1] = mk(4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h51);
        tv1[2] = mk(4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h51);
        tv1[3] = mk(4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h51);
        tv1[4] = mk(4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h51);
        tv1[5] = mk(4'b1000, 1'b1, 4'b1000, 1'b1, 2'd1, 8'h51);
        tv1[6] = mk(4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h53);
        tv1[7] = mk(4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3, 8'h53);
        tv1[8] = mk(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 8'h53);

        @(posedge clk);
        #1;

        for (int k = 0; k < 24; k++) begin
            if (k == 2) rst0 = 1'b0;
            apply_vec(0, k, tv0[k]);
        end

        rst1 = 1'b0;
        for (int k = 0; k < 9; k++) begin
            apply_vec(1, k, tv1[k]);
        end

        // ---- u2: N=3, WIDTH=16, reset while a word is stalled ----
        step2(0, 1'b0, 3'b111, 1'b0, 3'b001, 1'b0, 2'd0, 16'h0000);
        step2(1, 1'b0, 3'b111, 1'b0, 3'b000, 1'b1, 2'd0, 16'hC000);
        step2(2, 1'b1, 3'b111, 1'b0, 3'b000, 1'b1, 2'd0, 16'hC000);
        step2(3, 1'b0, 3'b111, 1'b1, 3'b001, 1'b0, 2'd0, 16'h0000);
        step2(4, 1'b0, 3'b111, 1'b1, 3'b010, 1'b1, 2'd0, 16'hC000);
        step2(5, 1'b0, 3'b111, 1'b1, 3'b100, 1'b1, 2'd1, 16'hC001);
        step2(6, 1'b0, 3'b111, 1'b1, 3'b001, 1'b1, 2'd2, 16'hC002);
        step2(7, 1'b0, 3'b111, 1'b1, 3'b010, 1'b1, 2'd0, 16'hC000);
        step2(8, 1'b0, 3'b000, 1'b1, 3'b000, 1'b1, 2'd1, 16'hC001);
        step2(9, 1'b0, 3'b000, 1'b1, 3'b000, 1'b0, 2'd1, 16'hC001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
